// File: rtl/fetch_unit.sv
// Instruction-fetch stage with IF/ID pipeline register and a one-entry skid buffer.
// Fetches from a variable-latency instruction memory; honours decode stall, redirect and halt.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  input  logic        halt_in,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic        fetch_halted,
  output logic [1:0]  dbg_state
);

  // Memory handshake: a word is accepted only in a cycle where imem_req=1 and
  // imem_valid=1; imem_rdata then belongs to the imem_addr driven that same cycle.
  // There is no back-pressure on memory: a word arriving under stall goes to the skid buffer.

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_HOLD = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_inst_q, buf_inst_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] inst_q, inst_d;
  logic        inst_valid_q, inst_valid_d;
  logic [31:0] pc_out_q, pc_out_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_RUN;
      pc_q         <= RESET_PC & 32'hFFFF_FFFC;
      buf_inst_q   <= 32'h0;
      buf_pc_q     <= 32'h0;
      inst_q       <= 32'h0;
      inst_valid_q <= 1'b0;
      pc_out_q     <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      buf_inst_q   <= buf_inst_d;
      buf_pc_q     <= buf_pc_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      pc_out_q     <= pc_out_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    buf_inst_d   = buf_inst_q;
    buf_pc_d     = buf_pc_q;
    inst_d       = inst_q;
    inst_valid_d = inst_valid_q;
    pc_out_d     = pc_out_q;

    if (state_q == S_HALT) begin
      state_d = S_HALT;
    end else if (redirect_en) begin
      // Any response or buffered word belongs to the wrong path and is dropped.
      pc_d         = redirect_pc & 32'hFFFF_FFFC;
      inst_d       = 32'h0;
      inst_valid_d = 1'b0;
      state_d      = S_RUN;
    end else if (halt_in) begin
      inst_d       = 32'h0;
      inst_valid_d = 1'b0;
      state_d      = S_HALT;
    end else begin
      case (state_q)
        S_RUN: begin
          if (imem_valid && !stall) begin
            inst_d       = imem_rdata;
            inst_valid_d = 1'b1;
            pc_out_d     = pc_q;
            pc_d         = pc_q + 32'd4;
          end else if (imem_valid) begin
            buf_inst_d = imem_rdata;
            buf_pc_d   = pc_q;
            pc_d       = pc_q + 32'd4;
            state_d    = S_HOLD;
          end else if (!stall) begin
            // Bubble keeps pc_out so the link value stays stable.
            inst_d       = 32'h0;
            inst_valid_d = 1'b0;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            inst_d       = buf_inst_q;
            inst_valid_d = 1'b1;
            pc_out_d     = buf_pc_q;
            state_d      = S_RUN;
          end
        end
        default: state_d = S_RUN;
      endcase
    end
  end

  assign imem_req     = (state_q == S_RUN) && !rst;
  assign imem_addr    = pc_q;
  assign inst         = inst_q;
  assign inst_valid   = inst_valid_q;
  assign pc_out       = pc_out_q;
  assign pc_plus4     = pc_out_q + 32'd4;
  assign fetch_halted = (state_q == S_HALT);
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: randomized and directed cycles checked against a queue-based
// behavioural model of the fetch stage; a second instance exercises PC wrap-around.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, stall, redirect_en, halt_in, imem_valid;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_req, inst_valid, fetch_halted;
  logic [31:0] imem_addr, inst, pc_out, pc_plus4;
  logic [1:0]  dbg_state;

  logic        imem_valid2;
  logic [31:0] imem_rdata2;
  logic        imem_req2, inst_valid2, fetch_halted2;
  logic [31:0] imem_addr2, inst2, pc_out2, pc_plus42;
  logic [1:0]  dbg_state2;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model: a PC, a halted flag, a queue of captured-but-undelivered words.
  logic [31:0] m_pc, m_inst, m_pcout;
  logic        m_vld, m_halted;
  logic [63:0] skid_q[$];

  logic        w2_en;
  logic [31:0] w2_pc;

  always #5 clk = ~clk;

  fetch_unit u_dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect_en(redirect_en),
    .redirect_pc(redirect_pc), .halt_in(halt_in), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .inst(inst), .inst_valid(inst_valid), .pc_out(pc_out), .pc_plus4(pc_plus4),
    .fetch_halted(fetch_halted), .dbg_state(dbg_state)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_dut2 (
    .clk(clk), .rst(rst), .stall(stall), .redirect_en(redirect_en),
    .redirect_pc(redirect_pc), .halt_in(halt_in), .imem_req(imem_req2),
    .imem_addr(imem_addr2), .imem_valid(imem_valid2), .imem_rdata(imem_rdata2),
    .inst(inst2), .inst_valid(inst_valid2), .pc_out(pc_out2), .pc_plus4(pc_plus42),
    .fetch_halted(fetch_halted2), .dbg_state(dbg_state2)
  );

  logic [132:0] dut_vec;
  assign dut_vec = {inst, inst_valid, pc_out, pc_plus4, imem_req, imem_addr, fetch_halted, dbg_state};

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a >> 2) ^ 32'h1357_0000;
  endfunction

  function logic [132:0] exp_vec();
    logic [1:0] st;
    st = m_halted ? 2'd2 : ((skid_q.size() != 0) ? 2'd1 : 2'd0);
    return {m_inst, m_vld, m_pcout, m_pcout + 32'd4,
            (!rst && !m_halted && skid_q.size() == 0), m_pc, m_halted, st};
  endfunction

  // Drive one cycle of inputs, advance the clock, then advance the model.
  task automatic step(input logic r, input logic st, input logic re,
                      input logic [31:0] rp, input logic h, input logic v);
    logic [31:0] rd;
    rd          = v ? mem_word(m_pc) : $urandom;
    rst         = r;
    stall       = st;
    redirect_en = re;
    redirect_pc = rp;
    halt_in     = h;
    imem_valid  = v;
    imem_rdata  = rd;
    imem_valid2 = w2_en;
    imem_rdata2 = mem_word(w2_pc);
    @(posedge clk);
    if (r) w2_pc = 32'hFFFF_FFF8;
    else if (w2_en) w2_pc = w2_pc + 32'd4;
    if (r) begin
      m_pc = 32'h0; m_halted = 1'b0; skid_q.delete();
      m_inst = 32'h0; m_vld = 1'b0; m_pcout = 32'h0;
    end else if (m_halted) begin
      m_halted = 1'b1;
    end else if (re) begin
      m_pc = rp & ~32'h3; m_inst = 32'h0; m_vld = 1'b0; skid_q.delete();
    end else if (h) begin
      m_halted = 1'b1; m_inst = 32'h0; m_vld = 1'b0;
    end else if (skid_q.size() != 0) begin
      if (!st) begin
        {m_inst, m_pcout} = skid_q.pop_front();
        m_vld = 1'b1;
      end
    end else if (v && !st) begin
      m_inst = rd; m_pcout = m_pc; m_vld = 1'b1; m_pc = m_pc + 32'd4;
    end else if (v) begin
      skid_q.push_back({rd, m_pc});
      m_pc = m_pc + 32'd4;
    end else if (!st) begin
      m_inst = 32'h0; m_vld = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'($urandom), 1'($urandom), $urandom, 1'($urandom), 1'($urandom));
      n_checks++;
      if (dut_vec !== exp_vec()) $display("FAIL reset cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
      else n_pass++;
    end
    n_checks++;
    if ({inst, inst_valid, pc_out, pc_plus4, imem_req, fetch_halted} !== {32'h0, 1'b0, 32'h0, 32'h4, 1'b0, 1'b0})
      $display("FAIL reset_values got inst=%h v=%b pc=%h p4=%h req=%b h=%b", inst, inst_valid, pc_out, pc_plus4, imem_req, fetch_halted);
    else n_pass++;
  endtask

  task automatic test_zero_wait();
    step(1'b1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      n_checks++;
      if (dut_vec !== exp_vec() || pc_out !== 32'(i * 4) || inst_valid !== 1'b1 || imem_req !== 1'b1)
        $display("FAIL zero_wait cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_wait_states();
    step(1'b1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, (i % 3) == 2);
      n_checks++;
      if (dut_vec !== exp_vec()) $display("FAIL wait_states cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_stall();
    step(1'b1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10 && m_pc != 32'h8; i++) step(1'b0, 0, 0, 0, 0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
      n_checks++;
      if (dut_vec !== exp_vec() || dbg_state !== 2'd1 || imem_req !== 1'b0 || pc_out !== 32'h4)
        $display("FAIL stall_hold cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
      else n_pass++;
    end
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    n_checks++;
    if (dut_vec !== exp_vec() || pc_out !== 32'h8 || inst !== mem_word(32'h8) || imem_addr !== 32'hC)
      $display("FAIL stall_drain got=%h exp=%h", dut_vec, exp_vec());
    else n_pass++;
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    n_checks++;
    if (dut_vec !== exp_vec() || pc_out !== 32'hC) $display("FAIL stall_resume got=%h exp=%h", dut_vec, exp_vec());
    else n_pass++;
  endtask

  task automatic test_redirect_hold();
    step(1'b1, 0, 0, 0, 0, 0);
    step(1'b0, 0, 0, 0, 0, 1'b1);
    step(1'b0, 1'b1, 0, 0, 0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 32'h103, 1'b0, 1'b1);
    n_checks++;
    if (dut_vec !== exp_vec() || imem_addr !== 32'h100 || inst_valid !== 1'b0 || imem_req !== 1'b1)
      $display("FAIL redirect_hold got=%h exp=%h", dut_vec, exp_vec());
    else n_pass++;
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    n_checks++;
    if (dut_vec !== exp_vec() || pc_out !== 32'h100 || inst_valid !== 1'b1)
      $display("FAIL redirect_target got=%h exp=%h", dut_vec, exp_vec());
    else n_pass++;
  endtask

  task automatic test_halt();
    step(1'b1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20 && m_pc != 32'h20; i++) step(1'b0, 0, 0, 0, 0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    n_checks++;
    if (dut_vec !== exp_vec() || fetch_halted !== 1'b1 || imem_req !== 1'b0 || inst_valid !== 1'b0)
      $display("FAIL halt_entry got=%h exp=%h", dut_vec, exp_vec());
    else n_pass++;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'($urandom), 1'($urandom), $urandom, 1'($urandom), 1'b1);
      n_checks++;
      if (dut_vec !== exp_vec() || fetch_halted !== 1'b1)
        $display("FAIL halt_sticky cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
      else n_pass++;
    end
    step(1'b1, 0, 0, 0, 0, 0);
    step(1'b0, 0, 0, 0, 0, 1'b1);
    n_checks++;
    if (dut_vec !== exp_vec() || pc_out !== 32'h0 || inst_valid !== 1'b1 || fetch_halted !== 1'b0)
      $display("FAIL halt_restart got=%h exp=%h", dut_vec, exp_vec());
    else n_pass++;
  endtask

  task automatic test_random();
    step(1'b1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0,
           $urandom, $urandom_range(0, 59) == 0, 1'($urandom));
      n_checks++;
      if (dut_vec !== exp_vec()) $display("FAIL random cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_wrap();
    logic [31:0] tab [3];
    tab = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    w2_en = 1'b0;
    step(1'b1, 0, 0, 0, 0, 0);
    w2_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      n_checks++;
      if (pc_out2 !== tab[i] || pc_plus42 !== tab[i] + 32'd4 || inst_valid2 !== 1'b1 || inst2 !== mem_word(tab[i]))
        $display("FAIL wrap cyc=%0d got pc=%h p4=%h v=%b inst=%h exp pc=%h p4=%h", i, pc_out2, pc_plus42,
                 inst_valid2, inst2, tab[i], tab[i] + 32'd4);
      else n_pass++;
    end
    w2_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_en = 1'b0; redirect_pc = 32'h0; halt_in = 1'b0;
    imem_valid = 1'b0; imem_rdata = 32'h0; imem_valid2 = 1'b0; imem_rdata2 = 32'h0;
    w2_en = 1'b0; w2_pc = 32'hFFFF_FFF8;
    m_pc = 32'h0; m_inst = 32'h0; m_pcout = 32'h0; m_vld = 1'b0; m_halted = 1'b0;
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_stall();
    test_redirect_hold();
    test_halt();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the decode stage. Holds the PC and requests instruction words from a variable-latency instruction memory. Presents `{inst, pc, pc_plus4}` to decode with a valid bit. Honours decode's stall, redirect (branch/jump/jr) and halt signals.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- stall  in  1  decode hazard stall; IF/ID register must hold its contents.
- redirect_en  in  1  decode resolved a taken branch/jump/jr this cycle.
- redirect_pc  in  32  target PC; bits [1:0] are ignored and treated as 0.
- halt_in  in  1  decode holds a valid halt instruction.
- imem_req  out  1  fetch request.
- imem_addr  out  32  word address; always equals the internal PC.
- imem_valid  in  1  imem_rdata is the word at the imem_addr driven this same cycle; meaningful only while imem_req=1.
- imem_rdata  in  32  instruction word.
- inst  out  32  IF/ID instruction (32'h0 = NOP on bubble).
- inst_valid  out  1  inst is a real fetched instruction.
- pc_out  out  32  PC of inst.
- pc_plus4  out  32  pc_out+4, used for the link value written to register 31.
- fetch_halted  out  1  fetch permanently stopped until reset.

## Operation
- Internal state:
  - pc (32 bits).
  - State register with states RUN, HOLD, HALT.
  - One-entry skid buffer {buf_inst, buf_pc}.
  - IF/ID register {inst, inst_valid, pc_out}.
- Reset:
  - pc=RESET_PC, state=RUN.
  - inst=0, inst_valid=0, pc_out=0, pc_plus4=4.
  - fetch_halted=0, skid buffer cleared.
- imem_req is 1 only in state RUN, and is 0 in the cycle rst is high.
- Priority each cycle: rst > redirect_en > halt_in > stall > normal.
- Redirect (RUN or HOLD):
  - pc←{redirect_pc[31:2],2'b00}.
  - IF/ID←bubble (inst=0, inst_valid=0); skid buffer discarded.
  - state←RUN.
  - An imem_valid in the same cycle is ignored.
- Halt, when halt_in=1 and redirect_en=0:
  - state←HALT, IF/ID←bubble.
  - pc holds.
- HALT state:
  - imem_req=0, fetch_halted=1.
  - All inputs except rst are ignored.
- RUN, no redirect/halt:
  - imem_valid=1, stall=0: IF/ID←{imem_rdata, pc, valid=1}; pc←pc+4.
  - imem_valid=1, stall=1: skid←{imem_rdata, pc}; pc←pc+4; state←HOLD; IF/ID holds.
  - imem_valid=0, stall=0: IF/ID←bubble (pc_out/pc_plus4 hold last values); pc holds.
  - imem_valid=0, stall=1: everything holds.
- HOLD, no redirect/halt:
  - imem_req=0, pc holds.
  - stall=1: hold.
  - stall=0: IF/ID←{buf_inst, buf_pc, valid=1}; state←RUN.
- Arithmetic:
  - pc+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0.
  - pc_plus4 = pc_out+4, same wrap rule.
  - pc[1:0] is always 00.

## Timing
- Fetch latency: an imem_valid accepted in cycle N appears on inst/inst_valid in cycle N+1.
- Throughput: 1 instruction/cycle while imem_valid=1 every cycle and stall=0.
- Stall with an arriving word:
  - The word is captured and is not lost.
  - Exactly one word is buffered.
  - No new request is issued until the buffer drains.
  - Drain occurs in the cycle after stall falls.
- Redirect:
  - Asserted in cycle N: imem_addr=target in cycle N+1.
  - inst_valid=0 in cycle N+1.
  - Earliest valid target instruction is at N+2.
- Halt asserted in cycle N: imem_req=0, fetch_halted=1 and inst_valid=0 from cycle N+1.
- rst mid-operation:
  - At the next edge, all state returns to reset values.
  - Any outstanding response or skid contents are dropped.

## Test plan
- Reset release with zero-wait memory returning addr>>2: inst_valid=1 from cycle 2. pc_out runs 0,4,8,C; pc_plus4 runs 4,8,C,10; imem_req=1 throughout.
- Memory with 2-cycle wait states: each inst_valid pulse is preceded by a bubble (inst=0, inst_valid=0). No PC is skipped or repeated.
- Stall high for 3 cycles, asserted in the cycle imem_valid returns word at 0x8:
  - state HOLD, imem_req=0 for 3 cycles, IF/ID frozen at 0x4.
  - After stall drops: pc_out=0x8, then fetch resumes at 0xC.
- redirect_en with redirect_pc=0x103 while in HOLD: buffer dropped; next cycle imem_addr=0x100 and inst_valid=0; pc_out=0x100 one cycle later.
- halt_in at pc 0x20: next cycle fetch_halted=1, imem_req=0, inst_valid=0. Stays halted through redirect_en and imem_valid pulses until rst, then restarts at RESET_PC.
- RESET_PC=32'hFFFF_FFF8: PCs FFFF_FFF8, FFFF_FFFC, 0000_0000; pc_plus4 for FFFF_FFFC is 0.
